// File: rtl/parity_rx_pkg.sv
// rtl/parity_rx_pkg.sv - shared state encodings and default frame constants for the parity link
package parity_rx_pkg;

    // Default frame shape, shared with the matching transmitter
    localparam int DEF_CLKS_PER_BIT = 4;
    localparam int DEF_DATA_BITS    = 8;
    localparam bit DEF_ODD_PARITY   = 1'b0;

    // Receiver states; encodings are fixed so other tools can decode them
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/parity_rx_bit_timer.sv
// rtl/parity_rx_bit_timer.sv - free-running bit timer with one sample strobe per wrap
module parity_rx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CLR,
    output logic TICK
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    // Clearing presets to half a bit so the first strobe lands mid start bit
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

    logic [CW-1:0] cnt;

    // Count up, wrap at the last cycle of a bit, preset to half a bit on clear
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt <= '0;
        end else if (CLR) begin
            cnt <= HALF;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign TICK = (cnt == LAST);

endmodule

// File: rtl/parity_rx.sv
// rtl/parity_rx.sv - serial frame receiver with parity and framing checks
module parity_rx
    import parity_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter bit ODD_PARITY   = DEF_ODD_PARITY
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] DATA_OUT,
    output logic                 VALID,
    output logic                 PAR_ERR,
    output logic                 FRAME_ERR,
    output logic                 BUSY
);

    localparam int            IW       = $clog2(DATA_BITS) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    rx_state_t            state;
    rx_state_t            state_next;
    logic                 sync1;
    logic                 rxs;
    logic                 tick;
    logic                 timer_clr;
    logic                 clr_idx;
    logic                 load_bit;
    logic                 load_par;
    logic                 load_stop;
    logic                 finish;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_next;
    logic                 pbit;
    logic                 stop_bit;
    logic                 stop_seen;

    parity_rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .CLK  (CLK),
        .RESET(RESET),
        .CLR  (timer_clr),
        .TICK (tick)
    );

    // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= RX;
            rxs   <= sync1;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle datapath strobes; sampling happens only on timer strobes
    always_comb begin
        state_next = state;
        timer_clr  = 1'b0;
        clr_idx    = 1'b0;
        load_bit   = 1'b0;
        load_par   = 1'b0;
        load_stop  = 1'b0;
        finish     = 1'b0;
        // Data arrives LSB first, so shifting in from the top leaves bit 0 in place after the last bit
        shift_next                = shift >> 1;
        shift_next[DATA_BITS-1]   = rxs;
        case (state)
            ST_IDLE: begin
                timer_clr = 1'b1;
                if (!rxs) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rxs) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_DATA;
                        clr_idx    = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    load_bit = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_next = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    load_par   = 1'b1;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Report one cycle after the stop sample, then go straight back to IDLE
                // regardless of the stop level so a held-low line re-triggers
                if (stop_seen) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end else if (tick) begin
                    load_stop = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Shift register, bit index, captured parity/stop bits and frame result outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            idx       <= '0;
            shift     <= '0;
            pbit      <= 1'b0;
            stop_bit  <= 1'b0;
            stop_seen <= 1'b0;
            DATA_OUT  <= '0;
            VALID     <= 1'b0;
            PAR_ERR   <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            VALID     <= finish;
            stop_seen <= load_stop;
            if (clr_idx) begin
                idx <= '0;
            end else if (load_bit) begin
                idx <= idx + IW'(1);
            end
            if (load_bit) begin
                shift <= shift_next;
            end
            if (load_par) begin
                pbit <= rxs;
            end
            if (load_stop) begin
                stop_bit <= rxs;
            end
            if (finish) begin
                DATA_OUT  <= shift;
                PAR_ERR   <= ((^shift) ^ pbit) != ODD_PARITY;
                FRAME_ERR <= ~stop_bit;
            end
        end
    end

    assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_parity_rx.sv
// tb/tb_parity_rx.sv - directed self-checking bench for parity_rx
module tb_parity_rx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a;
    logic       rx_b;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic       valid_a;
    logic       valid_b;
    logic       par_err_a;
    logic       par_err_b;
    logic       frame_err_a;
    logic       frame_err_b;
    logic       busy_a;
    logic       busy_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int valid_cyc_a = 0;
    logic busy_at_valid_a = 1'b1;
    logic [9:0] q_a[$];
    logic [9:0] q_b[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    parity_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8),
        .ODD_PARITY  (1'b0)
    ) u_even (
        .CLK      (clk),
        .RESET    (rst),
        .RX       (rx_a),
        .DATA_OUT (data_a),
        .VALID    (valid_a),
        .PAR_ERR  (par_err_a),
        .FRAME_ERR(frame_err_a),
        .BUSY     (busy_a)
    );

    parity_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8),
        .ODD_PARITY  (1'b1)
    ) u_odd (
        .CLK      (clk),
        .RESET    (rst),
        .RX       (rx_b),
        .DATA_OUT (data_b),
        .VALID    (valid_b),
        .PAR_ERR  (par_err_b),
        .FRAME_ERR(frame_err_b),
        .BUSY     (busy_b)
    );

    // Record every VALID cycle with the results presented alongside it
    always @(negedge clk) begin
        if (valid_a) begin
            q_a.push_back({data_a, par_err_a, frame_err_a});
            valid_cyc_a     = cyc;
            busy_at_valid_a = busy_a;
        end
        if (valid_b) begin
            q_b.push_back({data_b, par_err_b, frame_err_b});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    task automatic send_bit(input bit sel, input logic v);
        drive(sel, v);
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input logic p, input logic s);
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
        send_bit(sel, p);
        send_bit(sel, s);
    endtask

    task automatic expect_frame(input string tag, input bit sel, input logic [7:0] d,
                                input logic pe, input logic fe);
        logic [9:0] e;
        int         n;
        n = sel ? q_b.size() : q_a.size();
        check({tag, " pulse"}, 32'(n > 0), 1);
        if (n > 0) begin
            if (sel) e = q_b.pop_front();
            else     e = q_a.pop_front();
            check({tag, " data"},      e[9:2], d);
            check({tag, " par_err"},   e[1],   pe);
            check({tag, " frame_err"}, e[0],   fe);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int   start;
        int   n_busy;
        rst  = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (3) @(negedge clk);
        check("reset data",      data_a,      8'h00);
        check("reset valid",     valid_a,     0);
        check("reset par_err",   par_err_a,   0);
        check("reset frame_err", frame_err_a, 0);
        check("reset busy",      busy_a,      0);
        check("reset busy odd",  busy_b,      0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: 0xA5, correct parity, latency from the first edge that captures the fall
        start = cyc + 1;
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("t1 latency", valid_cyc_a - start, 45);
        check("t1 idle in valid cycle", busy_at_valid_a, 0);
        expect_frame("t1", 0, 8'hA5, 1'b0, 1'b0);
        check("t1 single pulse", q_a.size(), 0);

        // 2: 0x01 with a wrong parity bit
        send_frame(0, 8'h01, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        expect_frame("t2", 0, 8'h01, 1'b1, 1'b0);

        // 5: back-to-back frames with no idle gap
        send_frame(0, 8'h3C, 1'b0, 1'b1);
        send_frame(0, 8'hC3, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        expect_frame("t5 first", 0, 8'h3C, 1'b0, 1'b0);
        expect_frame("t5 second", 0, 8'hC3, 1'b0, 1'b0);
        check("t5 pulse count", q_a.size(), 0);

        // 4: one-cycle low glitch is rejected at the start mid-sample
        drive(0, 1'b0);
        @(negedge clk);
        drive(0, 1'b1);
        n_busy = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy_a) n_busy++;
        end
        check("t4 busy brief", 32'(n_busy > 0 && n_busy <= 4), 1);
        check("t4 busy end", busy_a, 0);
        check("t4 no valid", q_a.size(), 0);
        check("t4 data held", data_a, 8'hC3);
        check("t4 par_err held", par_err_a, 0);

        // 6: load non-zero results, then reset in the middle of DATA bit 4
        send_frame(0, 8'h96, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        expect_frame("t6 pre", 0, 8'h96, 1'b1, 1'b0);
        send_bit(0, 1'b0);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        drive(0, 1'b1);
        repeat (2) @(negedge clk);
        check("t6 busy before reset", busy_a, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6 reset data", data_a, 8'h00);
        check("t6 reset par_err", par_err_a, 0);
        check("t6 reset frame_err", frame_err_a, 0);
        check("t6 reset valid", valid_a, 0);
        check("t6 reset busy", busy_a, 0);
        rst  = 1'b0;
        rx_a = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("t6 abandoned no valid", q_a.size(), 0);
        send_frame(0, 8'h5A, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        expect_frame("t6 after", 0, 8'h5A, 1'b0, 1'b0);

        // 3: stop bit 0 with the line held low afterwards
        send_frame(0, 8'hFF, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        expect_frame("t3", 0, 8'hFF, 1'b0, 1'b1);
        check("t3 idle in valid cycle", busy_at_valid_a, 0);
        check("t3 retrigger busy", busy_a, 1);
        rx_a = 1'b1;
        repeat (80) @(negedge clk);
        check("t3 settled", busy_a, 0);
        q_a.delete();

        // 7: odd parity instance
        send_frame(1, 8'h00, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        expect_frame("t7 odd ok", 1, 8'h00, 1'b0, 1'b0);
        send_frame(1, 8'h00, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        expect_frame("t7 odd bad", 1, 8'h00, 1'b1, 1'b0);
        send_frame(1, 8'h80, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        expect_frame("t7 odd 80", 1, 8'h80, 1'b0, 1'b0);
        check("t7 even side quiet", q_a.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
